instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Brief   : Instruction fetch unit with IDLE/FETCH/EXEC/ERR control and
//           next-PC selection. The optional fetch timeout is enabled by
//           defining INSTR_FETCH_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  Opcode,
  output logic [5:0]  Function,
  output logic [31:0] pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic        w_timeout;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  // Jump wins over a taken branch; every term keeps bits [1:0] at zero.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (Jump) begin
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (Branch && Zero) begin
      w_next_pc = w_pc_plus4 + w_br_off;
    end
  end

`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam logic [3:0] C_TIMEOUT_LAST = 4'd15;

  logic [3:0] r_wait_cnt;

  // Held at zero outside FETCH, so it starts from zero on every FETCH entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state != FETCH) begin
      r_wait_cnt <= 4'd0;
    end else if (!imem_ack) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign w_timeout = (r_state == FETCH) && !imem_ack && (r_wait_cnt == C_TIMEOUT_LAST);
  assign fetch_err = (r_state == ERR);
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    imem_addr   = 32'h0000_0000;
    instr_valid = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = r_pc;
        if (imem_ack) begin
          w_state_nxt = EXEC;
        end else if (w_timeout) begin
          w_state_nxt = ERR;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= 32'h0000_0000;
      r_instr <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == FETCH) && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if ((r_state == EXEC) && !stall) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign instr    = r_instr;
  assign pc       = r_pc;
  assign Opcode   = r_instr[31:26];
  assign Function = r_instr[5:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Directed scoreboard bench for instr_fetch; expected fetch
//           addresses are queued when an instruction retires.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        Branch = 1'b0;
  logic        Jump = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  Opcode;
  logic [5:0]  Function;
  logic [31:0] pc;
  logic        fetch_err;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tb_pc = 32'h0;

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .Branch     (Branch),
    .Jump       (Jump),
    .Zero       (Zero),
    .instr      (instr),
    .instr_valid(instr_valid),
    .Opcode     (Opcode),
    .Function   (Function),
    .pc         (pc),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Waits (bounded) for a request and checks it against the scoreboard head.
  task automatic wait_fetch(input int exp_lat);
    int          k;
    logic [31:0] e;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_latency", k, exp_lat);
    chk("imem_req", imem_req, 1'b1);
    chk("fetch_err_clear", fetch_err, 1'b0);
    chk("sb_level", exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_addr", imem_addr, e);
      tb_pc = e;
    end
  endtask

  // One instruction: fetch with wait states, optional stall, then retire.
  task automatic step(input logic [31:0] word, input int lat, input int waits,
                      input int stalls, input logic br, input logic j,
                      input logic z, input logic [31:0] exp_next);
    wait_fetch(lat);
    chk("valid_in_fetch", instr_valid, 1'b0);
    imem_rdata = word;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("req_held", imem_req, 1'b1);
      chk("addr_held", imem_addr, tb_pc);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("valid_exec", instr_valid, 1'b1);
    chk("instr", instr, word);
    chk("pc", pc, tb_pc);
    chk("opcode", Opcode, word[31:26]);
    chk("function", Function, word[5:0]);
    if (stalls > 0) stall = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("stall_pc", pc, tb_pc);
      chk("stall_instr", instr, word);
      chk("stall_opcode", Opcode, word[31:26]);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_valid", instr_valid, 1'b1);
    end
    stall  = 1'b0;
    Branch = br;
    Jump   = j;
    Zero   = z;
    exp_q.push_back(exp_next);
    @(negedge clk);
    Branch = 1'b0;
    Jump   = 1'b0;
    Zero   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", fetch_err, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_hold_req", imem_req, 1'b0);
    chk("rst_hold_instr", instr, 32'h0);
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  initial begin
    do_reset();

    // Sequential fetch from 0; the first request follows one IDLE cycle.
    step(32'h2001_0001, 1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h4);
    step(32'h2002_0002, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h8);
    step(32'h2003_0003, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'hC);
    step(32'h2004_0004, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h10);

    // Branch at 0x10: taken goes back to 0x0C, not taken falls to 0x14.
    step(32'h1000_FFFE, 0, 0, 0, 1'b1, 1'b0, 1'b1, 32'hC);
    step(32'h2005_0005, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h10);
    step(32'h1000_FFFE, 0, 0, 0, 1'b1, 1'b0, 1'b0, 32'h14);

    // Stall for three cycles, then wait states on memory.
    step(32'h8C22_0004, 0, 0, 3, 1'b0, 1'b0, 1'b0, 32'h18);
    step(32'hAC43_0008, 0, 2, 0, 1'b0, 1'b0, 1'b0, 32'h1C);

    // Backward branch to the top word, then wrap to zero.
    step(32'h1000_FFF7, 0, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(32'h2006_0006, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Climb to 0x3000_0000 in maximum forward branch strides.
    for (int i = 0; i < 6144; i++) begin
      step(32'h1000_7FFF, 0, 0, 0, 1'b1, 1'b0, 1'b1, exp_q[0] + 32'h0002_0000);
    end
    for (int i = 0; i < 8; i++) begin
      step(32'h2007_0007, 0, 0, 0, 1'b0, 1'b0, 1'b0, exp_q[0] + 32'h4);
    end
    chk("climb_pc", exp_q[0], 32'h3000_0020);

    // Jump has priority over a taken branch.
    step(32'h0800_0040, 0, 0, 0, 1'b1, 1'b1, 1'b1, 32'h3000_0100);

    // Reset in the middle of the fetch at 0x3000_0100; restart at 0.
    wait_fetch(0);
    do_reset();
    step(32'h2008_0008, 1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h4);

`ifdef INSTR_FETCH_TIMEOUT_EN
    // Ack in the 16th FETCH cycle is an ordinary capture.
    step(32'h2009_0009, 0, 15, 0, 1'b0, 1'b0, 1'b0, 32'h8);
    chk("late_ack_err", fetch_err, 1'b0);
    wait_fetch(0);
    repeat (15) @(negedge clk);
    chk("timeout_15_req", imem_req, 1'b1);
    chk("timeout_15_err", fetch_err, 1'b0);
    @(negedge clk);
    chk("timeout_err", fetch_err, 1'b1);
    chk("timeout_req", imem_req, 1'b0);
    imem_ack = 1'b1;
    repeat (4) @(negedge clk);
    imem_ack = 1'b0;
    chk("err_sticky", fetch_err, 1'b1);
    chk("err_valid", instr_valid, 1'b0);
    do_reset();
    chk("err_cleared", fetch_err, 1'b0);
    step(32'h200A_000A, 1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h4);
`else
    // Without the timeout the fetch waits as long as memory takes.
    step(32'h2009_0009, 0, 40, 0, 1'b0, 1'b0, 1'b0, 32'h8);
    chk("no_timeout_err", fetch_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
